nfc_multi_channel_scheduler: RTL and testbench

- Parametrised multi-channel command front-end for the NAND flash controller core.
- Each of NCH host channels pushes commands into its own FIFO.
- A round-robin scheduler issues one command at a time to the core over the nfc_cmd/RWA/nfc_start/nfc_done/command_error handshake, then returns per-channel completion status.
- Adds queueing, fairness and a done-timeout watchdog, none of which the single-channel controller port has.

---
 rtl/nfc_sched_pkg.sv | 16 +
 rtl/nfc_cmd_fifo.sv | 47 ++++
 rtl/nfc_multi_channel_scheduler.sv | 152 +++++++++++++++
 tb/tb_nfc_multi_channel_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nfc_sched_pkg.sv
// Shared state encodings and completion status codes for the multi-channel
// NAND command scheduler.
package nfc_sched_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t START = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t RESP  = 2'd3;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_CMDERR  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/nfc_cmd_fifo.sv
// Single-clock FIFO holding one {cmd, addr} entry per slot; pointers carry an
// extra wrap bit so full and empty are told apart without a counter.
module nfc_cmd_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nfc_multi_channel_scheduler.sv
// Per-channel command queues with a round-robin issuer driving the single
// NAND controller core port, plus a watchdog on the core's done handshake.
//
// state | meaning
// IDLE  | pick next non-empty channel from rr pointer, pop its head
// START | one-cycle nfc_start pulse, watchdog cleared
// WAIT  | waiting for nfc_done or watchdog expiry
// RESP  | one-cycle rsp_valid on the granted channel, advance rr pointer
module nfc_multi_channel_scheduler
    import nfc_sched_pkg::*;
#(
    parameter int NCH          = 4,
    parameter int QDEPTH       = 4,
    parameter int CommandWidth = 3,
    parameter int AddressWidth = 16,
    parameter int TIMEOUT      = 1024
) (
    input  logic                        clk,
    input  logic                        Reset,
    input  logic [NCH-1:0]              req_valid,
    output logic [NCH-1:0]              req_ready,
    input  logic [NCH*CommandWidth-1:0] req_cmd,
    input  logic [NCH*AddressWidth-1:0] req_addr,
    output logic [NCH-1:0]              rsp_valid,
    output logic [1:0]                  rsp_status,
    output logic [CommandWidth-1:0]     nfc_cmd,
    output logic [AddressWidth-1:0]     RWA,
    output logic                        nfc_start,
    input  logic                        nfc_done,
    input  logic                        command_error,
    output logic                        busy
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int EW  = CommandWidth + AddressWidth;
    localparam int TW  = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    state_t                    state;
    logic [CHW-1:0]            rr_ptr;
    logic [CHW-1:0]            grant;
    logic [TW-1:0]             tcnt;
    logic [1:0]                status_q;
    logic [CommandWidth-1:0]   cmd_q;
    logic [AddressWidth-1:0]   addr_q;

    logic [NCH-1:0]            full;
    logic [NCH-1:0]            empty;
    logic [NCH-1:0]            push;
    logic [NCH-1:0]            pop;
    logic [NCH-1:0][EW-1:0]    head;

    logic                      arb_found;
    logic [CHW-1:0]            arb_sel;
    logic [CHW-1:0]            arb_idx;

    assign req_ready = ~full;
    assign push      = req_valid & ~full;

    for (genvar i = 0; i < NCH; i++) begin : g_fifo
        nfc_cmd_fifo #(
            .W     (EW),
            .DEPTH (QDEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (Reset),
            .push  (push[i]),
            .din   ({req_cmd[i*CommandWidth +: CommandWidth], req_addr[i*AddressWidth +: AddressWidth]}),
            .pop   (pop[i]),
            .dout  (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    // First non-empty channel scanning upward from rr_ptr, wrapping at NCH.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            arb_idx = CHW'((int'(rr_ptr) + k) % NCH);
            if (!arb_found && !empty[arb_idx]) begin
                arb_found = 1'b1;
                arb_sel   = arb_idx;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (state == IDLE && arb_found) begin
            pop[arb_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            tcnt     <= '0;
            status_q <= ST_OK;
            cmd_q    <= '0;
            addr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        {cmd_q, addr_q} <= head[arb_sel];
                        grant           <= arb_sel;
                        state           <= START;
                    end
                end
                START: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    // A done arriving on the expiry cycle still reports the core's result.
                    if (nfc_done) begin
                        status_q <= command_error ? ST_CMDERR : ST_OK;
                        state    <= RESP;
                    end else if (tcnt == TCNT_LAST) begin
                        status_q <= ST_TIMEOUT;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr <= (grant == CHW'(NCH - 1)) ? '0 : grant + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) begin
            rsp_valid[grant] = 1'b1;
        end
    end

    assign rsp_status = status_q;
    assign nfc_cmd    = cmd_q;
    assign RWA        = addr_q;
    assign nfc_start  = (state == START);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_nfc_multi_channel_scheduler.sv
// Directed bench: expected issues are queued as commands are pushed and
// popped when the scheduler starts the core; a small core model answers.
module tb_nfc_multi_channel_scheduler;

    localparam int NCH = 4;
    localparam int CW  = 3;
    localparam int AW  = 16;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              Reset = 1'b1;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH*CW-1:0] req_cmd;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH-1:0]    rsp_valid;
    logic [1:0]        rsp_status;
    logic [CW-1:0]     nfc_cmd;
    logic [AW-1:0]     RWA;
    logic              nfc_start;
    logic              nfc_done;
    logic              command_error;
    logic              busy;

    always #5 clk = ~clk;

    nfc_multi_channel_scheduler #(
        .NCH          (NCH),
        .QDEPTH       (4),
        .CommandWidth (CW),
        .AddressWidth (AW),
        .TIMEOUT      (TO)
    ) dut (
        .clk           (clk),
        .Reset         (Reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cmd       (req_cmd),
        .req_addr      (req_addr),
        .rsp_valid     (rsp_valid),
        .rsp_status    (rsp_status),
        .nfc_cmd       (nfc_cmd),
        .RWA           (RWA),
        .nfc_start     (nfc_start),
        .nfc_done      (nfc_done),
        .command_error (command_error),
        .busy          (busy)
    );

    typedef struct packed {
        logic [1:0]    ch;
        logic [CW-1:0] cmd;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t          exp_q[$];
    int            n_pass  = 0;
    int            n_total = 0;
    int            cur_ch  = 0;
    logic [CW-1:0] cur_cmd;
    logic [AW-1:0] cur_addr;
    int            lat;
    int            cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input int ch, input logic [CW-1:0] cmd, input logic [AW-1:0] addr, input bit track);
        exp_t e;
        req_valid[ch]          = 1'b1;
        req_cmd[ch*CW +: CW]   = cmd;
        req_addr[ch*AW +: AW]  = addr;
        if (track) begin
            e.ch   = 2'(ch);
            e.cmd  = cmd;
            e.addr = addr;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset(input bit full_check);
        Reset         = 1'b1;
        req_valid     = '0;
        nfc_done      = 1'b0;
        command_error = 1'b0;
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        exp_q.delete();
        chk("rst_ready", req_ready, 4'hF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 4'h0);
        if (full_check) begin
            chk("rst_status", rsp_status, 2'b00);
            chk("rst_start", nfc_start, 1'b0);
            chk("rst_cmd", nfc_cmd, 3'b000);
            chk("rst_rwa", RWA, 16'h0000);
        end
    endtask

    // Returns the number of cycles waited; the head of exp_q names the command expected at the core.
    task automatic wait_start(input string tag, output int waited);
        exp_t e;
        waited = 0;
        while (nfc_start !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_start"}, nfc_start, 1'b1);
        chk({tag, "_queued"}, (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) begin
            e        = exp_q.pop_front();
            cur_ch   = int'(e.ch);
            cur_cmd  = e.cmd;
            cur_addr = e.addr;
            chk({tag, "_cmd"}, nfc_cmd, cur_cmd);
            chk({tag, "_rwa"}, RWA, cur_addr);
        end
    endtask

    task automatic complete(input string tag, input int delay, input logic err, input logic [1:0] st);
        logic [NCH-1:0] exp_v;
        exp_v = 4'b0001 << cur_ch;
        repeat (delay) @(negedge clk);
        chk({tag, "_hold"}, {nfc_cmd, RWA}, {cur_cmd, cur_addr});
        nfc_done      = 1'b1;
        command_error = err;
        @(negedge clk);
        nfc_done      = 1'b0;
        command_error = 1'b0;
        chk({tag, "_rsp_valid"}, rsp_valid, exp_v);
        chk({tag, "_rsp_status"}, rsp_status, st);
        @(negedge clk);
        chk({tag, "_rsp_clear"}, rsp_valid, 4'h0);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        req_valid     = '0;
        req_cmd       = '0;
        req_addr      = '0;
        nfc_done      = 1'b0;
        command_error = 1'b0;
        @(negedge clk);
        do_reset(1'b1);

        // Single command on ch2: start two cycles after push, done 5 cycles later.
        drive(2, 3'b010, 16'h1A2B, 1'b1);
        @(negedge clk);
        req_valid = '0;
        chk("t1_no_early_start", nfc_start, 1'b0);
        wait_start("t1", lat);
        chk("t1_push_to_start", lat + 1, 2);
        complete("t1", 5, 1'b0, 2'b00);

        // All four channels at once from rr=0; then ch0 vs ch3 shows rr wrapped to 0.
        do_reset(1'b0);
        drive(0, 3'd1, 16'h1000, 1'b1);
        drive(1, 3'd2, 16'h2111, 1'b1);
        drive(2, 3'd3, 16'h3222, 1'b1);
        drive(3, 3'd4, 16'h4333, 1'b1);
        @(negedge clk);
        req_valid = '0;
        for (int k = 0; k < NCH; k++) begin
            wait_start("t2", lat);
            complete("t2", 2 + k, 1'b0, 2'b00);
        end
        drive(0, 3'd5, 16'h5A5A, 1'b1);
        drive(3, 3'd6, 16'h6B6B, 1'b1);
        @(negedge clk);
        req_valid = '0;
        wait_start("t2_wrap0", lat);
        complete("t2_wrap0", 1, 1'b0, 2'b00);
        wait_start("t2_wrap3", lat);
        complete("t2_wrap3", 1, 1'b0, 2'b00);

        // Hold the core on a ch0 command while ch1 fills; 5th push is dropped.
        drive(0, 3'd7, 16'h0F0F, 1'b1);
        @(negedge clk);
        req_valid = '0;
        wait_start("t3_ch0", lat);
        for (int k = 0; k < 4; k++) begin
            drive(1, 3'(k), 16'hC100 + 16'(k), 1'b1);
            @(negedge clk);
            req_valid = '0;
            chk("t3_ready_after_push", req_ready[1], (k < 3) ? 1'b1 : 1'b0);
        end
        drive(1, 3'd7, 16'hDEAD, 1'b0);
        @(negedge clk);
        req_valid = '0;
        chk("t3_ready_full", req_ready[1], 1'b0);
        complete("t3_ch0", 1, 1'b0, 2'b00);
        for (int k = 0; k < 4; k++) begin
            wait_start("t3_ch1", lat);
            complete("t3_ch1", 1, 1'b0, 2'b00);
        end
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (nfc_start) cnt++;
        end
        chk("t3_fifth_dropped", cnt, 0);

        // Error completion on ch3, the queued follow-up still issues.
        drive(3, 3'd5, 16'h3333, 1'b1);
        @(negedge clk);
        drive(3, 3'd6, 16'h4444, 1'b1);
        @(negedge clk);
        req_valid = '0;
        wait_start("t4_err", lat);
        complete("t4_err", 3, 1'b1, 2'b01);
        wait_start("t4_next", lat);
        complete("t4_next", 2, 1'b0, 2'b00);
        nfc_done      = 1'b1;
        command_error = 1'b1;
        @(negedge clk);
        nfc_done      = 1'b0;
        command_error = 1'b0;
        chk("t4_done_idle_rsp", rsp_valid, 4'h0);
        chk("t4_done_idle_busy", busy, 1'b0);

        // Core never answers: TIMEOUT WAIT cycles, then the RESP cycle.
        drive(0, 3'd3, 16'hBEEF, 1'b1);
        @(negedge clk);
        req_valid = '0;
        wait_start("t5", lat);
        cnt = 0;
        while (rsp_valid === 4'h0 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("t5_timeout_cycles", cnt, TO + 1);
        chk("t5_rsp_valid", rsp_valid, 4'b0001);
        chk("t5_status", rsp_status, 2'b10);
        @(negedge clk);
        chk("t5_back_idle", busy, 1'b0);

        // Reset in WAIT with three commands still queued.
        do_reset(1'b0);
        drive(0, 3'd1, 16'hA000, 1'b1);
        drive(1, 3'd2, 16'hA111, 1'b1);
        drive(2, 3'd3, 16'hA222, 1'b1);
        drive(3, 3'd4, 16'hA333, 1'b1);
        @(negedge clk);
        req_valid = '0;
        wait_start("t6", lat);
        repeat (2) @(negedge clk);
        chk("t6_in_wait", busy, 1'b1);
        Reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t6_rsp_in_reset", rsp_valid, 4'h0);
        end
        Reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t6_ready", req_ready, 4'hF);
        chk("t6_busy", busy, 1'b0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (nfc_start || rsp_valid != 4'h0) cnt++;
        end
        chk("t6_quiet", cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
